// File: rtl/scs8hd_mux2i_arb_pkg.sv
// Shared types and widths for the mux2i arbiter/sequencer.
// State encoding, counter widths and a saturating increment helper.
package scs8hd_mux2i_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_GRANT  = 2'd2;

    localparam int GUARD_W = 4;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETTLE = ST_SETTLE,
        GRANT  = ST_GRANT
    } state_t;

    function automatic logic [HOLD_W-1:0] hold_sat_inc(
        input logic [HOLD_W-1:0] v
    );
        return (v == {HOLD_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/scs8hd_rr_pick2.sv
// Two-way round-robin pick: sole requester wins,
// a tie goes to the requester that did not win last.
module scs8hd_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/scs8hd_mux2i_arb.sv
// Round-robin arbiter and sequencer for a shared inverting 2:1 mux,
// with settle cycles on every select change and a registered result.
module scs8hd_mux2i_arb
    import scs8hd_mux2i_arb_pkg::*;
#(
    parameter int DW       = 8,
    parameter int GUARD    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic          CLK,
    input  logic          RESETB,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic [DW-1:0] A0,
    input  logic [DW-1:0] A1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          S,
    output logic          BUSY,
    output logic [DW-1:0] Y,
    output logic          YVLD
);

    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MAX_HOLD);

    state_t             state;
    state_t             state_n;
    logic               win;
    logic               win_n;
    logic               last;
    logic               last_n;
    logic               sel_n;
    logic [GUARD_W-1:0] guard;
    logic [GUARD_W-1:0] guard_n;
    logic [HOLD_W-1:0]  hold;
    logic [HOLD_W-1:0]  hold_n;
    logic [HOLD_W-1:0]  hold_inc;
    logic               pick;
    logic               any;
    logic               req_w;
    logic               req_o;
    logic               go;
    logic               tgt;

    scs8hd_rr_pick2 u_pick (
        .req    ({REQ1, REQ0}),
        .last   (last),
        .winner (pick),
        .any    (any)
    );

    assign req_w    = win ? REQ1 : REQ0;
    assign req_o    = win ? REQ0 : REQ1;
    assign hold_inc = hold_sat_inc(hold);

    always_comb begin
        state_n = state;
        win_n   = win;
        last_n  = last;
        sel_n   = S;
        guard_n = guard;
        hold_n  = hold;
        go      = 1'b0;
        tgt     = pick;
        unique case (state)
            IDLE: begin
                hold_n = '0;
                go     = any;
            end
            SETTLE: begin
                if (!req_w) begin
                    // abandon; select is left where it is
                    state_n = IDLE;
                    guard_n = '0;
                    go      = any;
                end else if (guard <= GUARD_W'(1)) begin
                    state_n = GRANT;
                    guard_n = '0;
                end else begin
                    guard_n = guard - 1'b1;
                end
            end
            GRANT: begin
                last_n = win;
                if (!req_w) begin
                    state_n = IDLE;
                    hold_n  = '0;
                    go      = any;
                end else if (req_o && hold_inc >= HOLD_MAX) begin
                    hold_n = '0;
                    go     = 1'b1;
                    tgt    = ~win;
                end else begin
                    hold_n = req_o ? hold_inc : '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // launch a grant toward tgt, settling first if S must move
        if (go) begin
            win_n = tgt;
            if (tgt == S) begin
                state_n = GRANT;
            end else begin
                sel_n   = tgt;
                guard_n = GUARD_INIT;
                state_n = (GUARD == 0) ? GRANT : SETTLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state <= IDLE;
            win   <= 1'b0;
            last  <= 1'b1;
            S     <= 1'b0;
            guard <= '0;
            hold  <= '0;
        end else begin
            state <= state_n;
            win   <= win_n;
            last  <= last_n;
            S     <= sel_n;
            guard <= guard_n;
            hold  <= hold_n;
        end
    end

    assign GNT0 = (state == GRANT) && !win;
    assign GNT1 = (state == GRANT) && win;
    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            Y    <= '0;
            YVLD <= 1'b0;
        end else if (GNT0 || GNT1) begin
            Y    <= ~(S ? A1 : A0);
            YVLD <= 1'b1;
        end else begin
            YVLD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scs8hd_mux2i_arb.sv
// Directed bench for scs8hd_mux2i_arb (DW=8, GUARD=1, MAX_HOLD=4).
module tb_scs8hd_mux2i_arb;

    logic       CLK;
    logic       RESETB;
    logic       REQ0;
    logic       REQ1;
    logic [7:0] A0;
    logic [7:0] A1;
    logic       GNT0;
    logic       GNT1;
    logic       S;
    logic       BUSY;
    logic [7:0] Y;
    logic       YVLD;

    int total = 0;
    int bad   = 0;

    scs8hd_mux2i_arb #(.DW(8), .GUARD(1), .MAX_HOLD(4)) dut (
        .CLK    (CLK),
        .RESETB (RESETB),
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .A0     (A0),
        .A1     (A1),
        .GNT0   (GNT0),
        .GNT1   (GNT1),
        .S      (S),
        .BUSY   (BUSY),
        .Y      (Y),
        .YVLD   (YVLD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        REQ0   = 1'b0;
        REQ1   = 1'b0;
        RESETB = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESETB = 1'b1;
    endtask

    // {GNT0,GNT1,S} per cycle under continuous contention
    logic [2:0] rr_exp [11] = '{
        3'b100, 3'b100, 3'b100, 3'b100, 3'b001,
        3'b011, 3'b011, 3'b011, 3'b011, 3'b000,
        3'b100
    };

    initial begin
        A0 = 8'h00;
        A1 = 8'h00;
        do_reset();
        chk("rst_gnt", {GNT0, GNT1}, 2'b00);
        chk("rst_s", S, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_y", {Y, YVLD}, 9'h000);

        // lone REQ0 with S already 0: grant next cycle
        REQ0 = 1'b1;
        A0   = 8'h0F;
        tick();
        chk("t1_gnt", {GNT0, GNT1, S}, 3'b100);
        chk("t1_busy", BUSY, 1'b1);
        chk("t1_yvld0", YVLD, 1'b0);
        tick();
        chk("t1_y", {Y, YVLD}, {8'hF0, 1'b1});
        REQ0 = 1'b0;
        tick();
        chk("t1_drop", {GNT0, GNT1}, 2'b00);
        tick();
        chk("t1_yhold", {Y, YVLD}, {8'hF0, 1'b0});

        // lone REQ1: S moves, one settle cycle, then grant
        REQ1 = 1'b1;
        A1   = 8'hAA;
        tick();
        chk("t2_settle", {GNT0, GNT1, S, BUSY}, 4'b0011);
        tick();
        chk("t2_gnt", {GNT0, GNT1, S}, 3'b011);
        tick();
        chk("t2_y", {Y, YVLD}, {8'h55, 1'b1});
        REQ1 = 1'b0;
        tick();
        chk("t2_drop", {GNT1, BUSY}, 2'b00);

        // tie after reset, then handover, then next tie
        do_reset();
        A0   = 8'h11;
        A1   = 8'h22;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        tick();
        chk("t3_first", {GNT0, GNT1, S}, 3'b100);
        REQ0 = 1'b0;
        tick();
        chk("t3_sw", {GNT0, GNT1, S, BUSY}, 4'b0011);
        tick();
        chk("t3_g1", {GNT0, GNT1, S}, 3'b011);
        REQ1 = 1'b0;
        tick();
        chk("t3_idle", {GNT0, GNT1, BUSY}, 3'b000);
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        tick();
        chk("t3_tie2", {GNT0, GNT1, S}, 3'b000);

        // continuous contention: 4-cycle alternation
        for (int i = 0; i < 11; i++) begin
            tick();
            chk($sformatf("t4_rr%0d", i), {GNT0, GNT1, S}, rr_exp[i]);
            if (i == 1) chk("t4_y0", Y, 8'hEE);
            if (i == 6) chk("t4_y1", Y, 8'hDD);
        end

        // REQ1 withdrawn during settle
        do_reset();
        REQ1 = 1'b1;
        tick();
        chk("t5_settle", {GNT1, S, BUSY}, 3'b011);
        REQ1 = 1'b0;
        tick();
        chk("t5_abandon", {GNT0, GNT1, S, BUSY, YVLD}, 5'b00100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_quiet", {GNT1, YVLD}, 2'b00);
        end

        // async reset mid-grant
        do_reset();
        REQ1 = 1'b1;
        A1   = 8'h5A;
        repeat (3) tick();
        chk("t6_pre", {GNT1, S, Y, YVLD}, {1'b1, 1'b1, 8'hA5, 1'b1});
        #1;
        RESETB = 1'b0;
        #1;
        chk("t6_async", {GNT0, GNT1, S, BUSY, Y, YVLD}, 13'h0);
        REQ1 = 1'b0;
        tick();
        RESETB = 1'b1;
        REQ0   = 1'b1;
        REQ1   = 1'b1;
        tick();
        chk("t6_tie", {GNT0, GNT1, S}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    always @(negedge CLK) begin
        if (GNT0 && GNT1) begin
            bad++;
            $display("FAIL overlap got=%b%b exp=not_both", GNT0, GNT1);
        end
    end

endmodule
